// File: rtl/fas_peak_detect.sv
// FFT peak detector: captures a frame of complex bins, scans one bin per cycle,
// and reports the index and squared magnitude of the largest bin.
module fas_peak_detect #(
  parameter int NBIN     = 16,
  parameter int DW       = 16,
  parameter int TIE_LAST = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_valid,
  input  logic [NBIN*2*DW-1:0]       fft_d,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NBIN)-1:0]    freq,
  output logic [2*DW-1:0]            mag_max,
  output logic                       overrun
);

  localparam int IW = $clog2(NBIN);
  localparam int BW = 2 * DW;
  localparam int FW = NBIN * BW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_nx;
  logic [FW-1:0]      frame;
  logic [IW-1:0]      idx, run_idx, cand_idx;
  logic [BW-1:0]      run_max, cand_max, mag, bin_w;
  logic signed [DW-1:0] re, im;
  logic signed [BW-1:0] re_sq, im_sq;
  logic               better, last, start;

  assign bin_w = frame[idx*BW +: BW];
  assign re    = bin_w[BW-1:DW];
  assign im    = bin_w[DW-1:0];
  // Squares are non-negative and at most 2^(2DW-2), so the unsigned sum never wraps.
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  assign better   = (idx == '0) || ((TIE_LAST != 0) ? (mag >= run_max) : (mag > run_max));
  assign cand_max = better ? mag : run_max;
  assign cand_idx = better ? idx : run_idx;
  assign last     = (idx == IW'(NBIN - 1));
  assign start    = fft_valid && (state != SCAN);

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE:    if (fft_valid) state_nx = SCAN;
      SCAN:    if (last) state_nx = DONE;
      DONE:    state_nx = fft_valid ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the frame register is a wide flop bank, not a RAM, so it is reset with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '0;
      idx     <= '0;
      run_max <= '0;
      run_idx <= '0;
      freq    <= '0;
      mag_max <= '0;
      overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state   <= state_nx;
      overrun <= fft_valid && (state == SCAN);
      if (start) begin
        frame   <= fft_d;
        idx     <= '0;
        run_max <= '0;
        run_idx <= '0;
      end else if (state == SCAN) begin
        idx     <= idx + IW'(1);
        run_max <= cand_max;
        run_idx <= cand_idx;
        if (last) begin
          freq    <= cand_idx;
          mag_max <= cand_max;
        end
      end
    end
  end

endmodule
